// File: rtl/gshare_ras_predictor.sv
// Fetch-side branch predictor: gshare PHT with sequential init,
// plus a speculative/committed return address stack.
module gshare_ras_predictor #(
  parameter int ADDR_WIDTH    = 14,
  parameter int PHT_IDX_WIDTH = 12,
  parameter int GH_WIDTH      = 8,
  parameter int CTR_WIDTH     = 2,
  parameter int RAS_DEPTH     = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     ready,
  input  logic                     lookup_valid,
  input  logic [ADDR_WIDTH-1:0]    lookup_pc,
  input  logic                     lookup_is_call,
  input  logic                     lookup_is_ret,
  output logic                     pred_taken,
  output logic [PHT_IDX_WIDTH-1:0] pred_idx,
  output logic [ADDR_WIDTH-1:0]    ras_target,
  output logic                     ras_hit,
  input  logic                     commit_b,
  input  logic [PHT_IDX_WIDTH-1:0] commit_idx,
  input  logic                     commit_taken,
  input  logic                     commit_call,
  input  logic                     commit_ret,
  input  logic                     flush
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int NW = PW + 1;
  localparam int SH = PHT_IDX_WIDTH - GH_WIDTH;
  localparam logic [CTR_WIDTH-1:0] CTR_INIT =
    CTR_WIDTH'((2 ** (CTR_WIDTH - 1)) - 1);
  localparam logic [CTR_WIDTH-1:0] CTR_MAX = '1;
  localparam logic [NW-1:0] FULL = NW'(RAS_DEPTH);

  typedef enum logic {S_INIT, S_RUN} state_e;

  state_e                   state_q;
  logic [PHT_IDX_WIDTH-1:0] init_cnt_q;
  logic                     ready_q;

  logic [CTR_WIDTH-1:0]  pht_q [2**PHT_IDX_WIDTH];
  logic [ADDR_WIDTH-1:0] stack_q [RAS_DEPTH];

  logic [GH_WIDTH-1:0]      gh_q, gh_d;
  logic [PW-1:0]            sp_q, sp_d, csp_q, csp_d;
  logic [NW-1:0]            cnt_q, cnt_d, ccnt_q, ccnt_d;
  logic                     pred_taken_q, pred_taken_d;
  logic [PHT_IDX_WIDTH-1:0] pred_idx_q, pred_idx_d;
  logic [ADDR_WIDTH-1:0]    ras_target_q, ras_target_d;
  logic                     ras_hit_q, ras_hit_d;

  logic [PHT_IDX_WIDTH-1:0] idx;
  logic                     pht_we;
  logic [PHT_IDX_WIDTH-1:0] pht_wa;
  logic [CTR_WIDTH-1:0]     pht_wd, cmt_ctr;
  logic                     ras_we;

  // ready lags the INIT->RUN transition by one cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_INIT;
      init_cnt_q <= '0;
      ready_q    <= 1'b0;
    end else begin
      unique case (state_q)
        S_INIT: begin
          init_cnt_q <= init_cnt_q + PHT_IDX_WIDTH'(1);
          if (init_cnt_q == '1) state_q <= S_RUN;
        end
        S_RUN: ready_q <= 1'b1;
        default: state_q <= S_INIT;
      endcase
    end
  end

  always_comb begin
    idx     = lookup_pc[PHT_IDX_WIDTH-1:0] ^ (PHT_IDX_WIDTH'(gh_q) << SH);
    cmt_ctr = pht_q[commit_idx];
    pht_we  = 1'b0;
    pht_wa  = init_cnt_q;
    pht_wd  = CTR_INIT;
    gh_d    = gh_q;
    if (state_q == S_INIT) begin
      pht_we = 1'b1;
    end else if (ready_q && commit_b) begin
      pht_we = 1'b1;
      pht_wa = commit_idx;
      gh_d   = GH_WIDTH'({gh_q, commit_taken});
      if (commit_taken)
        pht_wd = (cmt_ctr == CTR_MAX) ? cmt_ctr : cmt_ctr + CTR_WIDTH'(1);
      else
        pht_wd = (cmt_ctr == '0) ? cmt_ctr : cmt_ctr - CTR_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && pht_we) pht_q[pht_wa] <= pht_wd;
  end

  always_comb begin
    csp_d  = csp_q;
    ccnt_d = ccnt_q;
    if (ready_q && commit_call) begin
      csp_d  = csp_q + PW'(1);
      ccnt_d = (ccnt_q == FULL) ? ccnt_q : ccnt_q + NW'(1);
    end else if (ready_q && commit_ret && ccnt_q != '0) begin
      csp_d  = csp_q - PW'(1);
      ccnt_d = ccnt_q - NW'(1);
    end
  end

  always_comb begin
    sp_d         = sp_q;
    cnt_d        = cnt_q;
    pred_taken_d = pred_taken_q;
    pred_idx_d   = pred_idx_q;
    ras_target_d = ras_target_q;
    ras_hit_d    = ras_hit_q;
    ras_we       = 1'b0;
    if (ready_q && flush) begin
      sp_d         = csp_d;
      cnt_d        = ccnt_d;
      pred_taken_d = 1'b0;
      ras_hit_d    = 1'b0;
    end else if (ready_q && lookup_valid) begin
      pred_idx_d   = idx;
      pred_taken_d = pht_q[idx][CTR_WIDTH-1];
      ras_hit_d    = 1'b0;
      if (lookup_is_call) begin
        ras_we = 1'b1;
        sp_d   = sp_q + PW'(1);
        cnt_d  = (cnt_q == FULL) ? cnt_q : cnt_q + NW'(1);
      end else if (lookup_is_ret) begin
        if (cnt_q != '0) begin
          ras_target_d = stack_q[sp_q - PW'(1)];
          ras_hit_d    = 1'b1;
          sp_d         = sp_q - PW'(1);
          cnt_d        = cnt_q - NW'(1);
        end else begin
          ras_target_d = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && ras_we) stack_q[sp_q] <= lookup_pc + ADDR_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gh_q         <= '0;
      sp_q         <= '0;
      cnt_q        <= '0;
      csp_q        <= '0;
      ccnt_q       <= '0;
      pred_taken_q <= 1'b0;
      pred_idx_q   <= '0;
      ras_target_q <= '0;
      ras_hit_q    <= 1'b0;
    end else begin
      gh_q         <= gh_d;
      sp_q         <= sp_d;
      cnt_q        <= cnt_d;
      csp_q        <= csp_d;
      ccnt_q       <= ccnt_d;
      pred_taken_q <= pred_taken_d;
      pred_idx_q   <= pred_idx_d;
      ras_target_q <= ras_target_d;
      ras_hit_q    <= ras_hit_d;
    end
  end

  assign ready      = ready_q;
  assign pred_taken = pred_taken_q;
  assign pred_idx   = pred_idx_q;
  assign ras_target = ras_target_q;
  assign ras_hit    = ras_hit_q;

endmodule

// File: tb/tb_gshare_ras_predictor.sv
// Randomized bench for gshare_ras_predictor against a
// behavioural model of the PHT, history and both RAS views.
module tb_gshare_ras_predictor;
  localparam int AW = 14;
  localparam int IW = 12;
  localparam int GW = 8;
  localparam int CW = 2;
  localparam int D  = 8;
  localparam int IMASK = (1 << IW) - 1;
  localparam int AMASK = (1 << AW) - 1;
  localparam int GMASK = (1 << GW) - 1;
  localparam int CMAX  = (1 << CW) - 1;
  localparam int CINIT = (1 << (CW - 1)) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          ready;
  logic          lookup_valid;
  logic [AW-1:0] lookup_pc;
  logic          lookup_is_call;
  logic          lookup_is_ret;
  logic          pred_taken;
  logic [IW-1:0] pred_idx;
  logic [AW-1:0] ras_target;
  logic          ras_hit;
  logic          commit_b;
  logic [IW-1:0] commit_idx;
  logic          commit_taken;
  logic          commit_call;
  logic          commit_ret;
  logic          flush;

  always #5 clk = ~clk;

  gshare_ras_predictor #(
    .ADDR_WIDTH(AW), .PHT_IDX_WIDTH(IW), .GH_WIDTH(GW),
    .CTR_WIDTH(CW), .RAS_DEPTH(D)
  ) dut (
    .clk(clk), .reset(reset), .ready(ready),
    .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .lookup_is_call(lookup_is_call), .lookup_is_ret(lookup_is_ret),
    .pred_taken(pred_taken), .pred_idx(pred_idx),
    .ras_target(ras_target), .ras_hit(ras_hit),
    .commit_b(commit_b), .commit_idx(commit_idx),
    .commit_taken(commit_taken), .commit_call(commit_call),
    .commit_ret(commit_ret), .flush(flush)
  );

  int errors = 0;
  int checks = 0;

  int pht_m [1 << IW];
  int stk_m [D];
  int gh_m, sp_m, cnt_m, csp_m, ccnt_m;
  int e_pt, e_idx, e_tgt, e_hit;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_in();
    lookup_valid = 0; lookup_pc = '0;
    lookup_is_call = 0; lookup_is_ret = 0;
    commit_b = 0; commit_idx = '0; commit_taken = 0;
    commit_call = 0; commit_ret = 0; flush = 0;
  endtask

  task automatic rand_in();
    lookup_valid = 1'($urandom);
    lookup_pc = AW'($urandom);
    lookup_is_call = 1'($urandom);
    lookup_is_ret = 1'($urandom);
    commit_b = 1'($urandom);
    commit_idx = IW'($urandom);
    commit_taken = 1'($urandom);
    commit_call = 1'($urandom);
    commit_ret = 1'($urandom);
    flush = 1'($urandom);
  endtask

  task automatic model_reset();
    for (int i = 0; i < (1 << IW); i++) pht_m[i] = CINIT;
    gh_m = 0; sp_m = 0; cnt_m = 0; csp_m = 0; ccnt_m = 0;
    e_pt = 0; e_idx = 0; e_tgt = 0; e_hit = 0;
  endtask

  function automatic int cur_idx(input int pc);
    return ((pc & IMASK) ^ (gh_m << (IW - GW))) & IMASK;
  endfunction

  // One clock of normal operation: predict, step, compare
  task automatic tick();
    int v;
    if (!flush && lookup_valid) begin
      e_idx = cur_idx(int'(lookup_pc));
      e_pt = pht_m[e_idx] >> (CW - 1);
      e_hit = 0;
      if (lookup_is_call) begin
        stk_m[sp_m] = (int'(lookup_pc) + 1) & AMASK;
        sp_m = (sp_m + 1) % D;
        if (cnt_m < D) cnt_m++;
      end else if (lookup_is_ret) begin
        if (cnt_m > 0) begin
          sp_m = (sp_m + D - 1) % D;
          e_tgt = stk_m[sp_m];
          e_hit = 1;
          cnt_m--;
        end else begin
          e_tgt = 0;
        end
      end
    end
    if (commit_b) begin
      v = pht_m[commit_idx];
      if (commit_taken) v = (v < CMAX) ? v + 1 : v;
      else v = (v > 0) ? v - 1 : v;
      pht_m[commit_idx] = v;
      gh_m = ((gh_m << 1) | int'(commit_taken)) & GMASK;
    end
    if (commit_call) begin
      csp_m = (csp_m + 1) % D;
      if (ccnt_m < D) ccnt_m++;
    end else if (commit_ret && ccnt_m > 0) begin
      csp_m = (csp_m + D - 1) % D;
      ccnt_m--;
    end
    if (flush) begin
      sp_m = csp_m; cnt_m = ccnt_m; e_hit = 0; e_pt = 0;
    end
    @(posedge clk); #1;
    chk("ready", ready, 1);
    chk("pred_taken", pred_taken, e_pt);
    chk("pred_idx", pred_idx, e_idx);
    chk("ras_hit", ras_hit, e_hit);
    chk("ras_target", ras_target, e_tgt);
    clear_in();
  endtask

  task automatic look(input int pc, input bit call, input bit ret);
    lookup_valid = 1; lookup_pc = AW'(pc);
    lookup_is_call = call; lookup_is_ret = ret;
    tick();
  endtask

  task automatic cmt_b(input int idx, input bit t);
    commit_b = 1; commit_idx = IW'(idx); commit_taken = t;
    tick();
  endtask

  // Reset, check reset state, then time the PHT sweep with junk inputs
  task automatic reset_and_init();
    int n = 0;
    bit seen = 0;
    reset = 1;
    rand_in();
    @(posedge clk); #1;
    reset = 0;
    clear_in();
    model_reset();
    chk("rst_ready", ready, 0);
    chk("rst_pred_taken", pred_taken, 0);
    chk("rst_pred_idx", pred_idx, 0);
    chk("rst_ras_hit", ras_hit, 0);
    chk("rst_ras_target", ras_target, 0);
    while (ready !== 1'b1 && n < 3 * (1 << IW)) begin
      if (n < (1 << IW) - 4) rand_in();
      else clear_in();
      @(posedge clk); #1;
      n++;
      if (pred_taken || ras_hit) seen = 1;
    end
    clear_in();
    chk("ready_latency", n, (1 << IW) + 1);
    chk("init_quiet", 32'(seen), 0);
  endtask

  task automatic rand_run(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      lookup_valid = ($urandom_range(0, 3) != 0);
      lookup_pc = AW'($urandom_range(0, 255));
      lookup_is_call = ($urandom_range(0, 5) == 0);
      lookup_is_ret = ($urandom_range(0, 5) == 0);
      commit_b = ($urandom_range(0, 2) == 0);
      commit_idx = ($urandom_range(0, 3) == 0) ?
                   IW'(cur_idx(int'(lookup_pc))) :
                   IW'($urandom_range(0, 255));
      commit_taken = 1'($urandom);
      case ($urandom_range(0, 9))
        0: commit_call = 1;
        1: commit_ret = 1;
        default: ;
      endcase
      flush = ($urandom_range(0, 19) == 0);
      tick();
    end
  endtask

  initial begin
    clear_in();
    reset = 0;
    reset_and_init();

    look(32'h10, 1, 0);
    look(32'h20, 1, 0);
    look(32'h100, 0, 1);
    chk("ret1_target", ras_target, 32'h21);
    chk("ret1_hit", ras_hit, 1);
    look(32'h101, 0, 1);
    chk("ret2_target", ras_target, 32'h11);
    chk("ret2_hit", ras_hit, 1);
    look(32'h102, 0, 1);
    chk("ret3_hit", ras_hit, 0);

    for (int i = 0; i < 9; i++) look(i, 1, 0);
    for (int i = 0; i < 9; i++) begin
      look(32'h200 + i, 0, 1);
      if (i < 8) begin
        chk("wrap_target", ras_target, 32'(9 - i));
        chk("wrap_hit", ras_hit, 1);
      end else begin
        chk("wrap_empty_hit", ras_hit, 0);
      end
    end

    flush = 1; tick();
    look(32'h30, 1, 0);
    look(32'h40, 1, 0);
    commit_call = 1; tick();
    commit_call = 1; tick();
    look(32'h50, 1, 0);
    look(32'h55, 0, 1);
    chk("spec_ret_target", ras_target, 32'h51);
    flush = 1; tick();
    chk("flush_pred_taken", pred_taken, 0);
    chk("flush_ras_hit", ras_hit, 0);
    look(32'h60, 0, 1);
    chk("recover_target", ras_target, 32'h41);
    chk("recover_hit", ras_hit, 1);

    cmt_b(100, 1);
    look(0, 0, 0);
    chk("gh_idx", pred_idx, 32'h010);

    for (int i = 0; i < 3; i++) cmt_b(5, 1);
    look(cur_idx(5) ^ 0 | (5 ^ cur_idx(5)) ^ cur_idx(5) ^ 5 ^ 5, 0, 0);
    look((5 ^ (gh_m << (IW - GW))) & IMASK, 0, 0);
    chk("sat_hi_idx", pred_idx, 5);
    chk("sat_hi_taken", pred_taken, 1);
    for (int i = 0; i < 4; i++) cmt_b(5, 0);
    look((5 ^ (gh_m << (IW - GW))) & IMASK, 0, 0);
    chk("sat_lo_idx", pred_idx, 5);
    chk("sat_lo_taken", pred_taken, 0);

    rand_run(3000);

    reset_and_init();
    rand_run(300);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
